// File: rtl/led_pkg.sv
// Shared definitions for the multi-channel LED blinker: mode encodings and
// the prescaler divide-ratio helper.
package led_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_OFF     = 2'd0;
  localparam logic [MODE_W-1:0] MODE_ON      = 2'd1;
  localparam logic [MODE_W-1:0] MODE_BLINK   = 2'd2;
  localparam logic [MODE_W-1:0] MODE_ONESHOT = 2'd3;

  // Clock cycles per tick; a zero tick rate yields 0 so the elaboration check trips.
  function automatic int unsigned calc_tick_div(input int unsigned clk_hz,
                                                input int unsigned tick_hz);
    return (tick_hz == 0) ? 0 : clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds its mode, period, on-time and tick counter, and
// produces a registered LED drive plus a one-cycle ONESHOT completion pulse.
module led_channel
  import led_pkg::*;
#(
  parameter int unsigned TIME_W     = 16,
  parameter int unsigned DEF_MODE   = 2,
  parameter int unsigned DEF_PERIOD = 1000,
  parameter int unsigned DEF_ON     = 500
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic              load,
  input  logic [MODE_W-1:0] cfg_mode,
  input  logic [TIME_W-1:0] cfg_period,
  input  logic [TIME_W-1:0] cfg_on,
  output logic              led,
  output logic              done
);

  logic [MODE_W-1:0] mode_q, mode_d;
  logic [TIME_W-1:0] period_q, period_d;
  logic [TIME_W-1:0] on_q, on_d;
  logic [TIME_W-1:0] cnt_q, cnt_d;
  logic [TIME_W-1:0] last_cnt;
  logic              led_q, led_d;
  logic              fin_q, fin_d;
  logic              done_q;

  // Period 0 behaves like period 1, so the counter never leaves 0.
  assign last_cnt = (period_q == '0) ? '0 : period_q - TIME_W'(1);

  // Next-state: a config load wins over a tick or a completion in the same cycle.
  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    on_d     = on_q;
    cnt_d    = cnt_q;
    fin_d    = 1'b0;
    if (load) begin
      mode_d   = cfg_mode;
      period_d = cfg_period;
      on_d     = cfg_on;
      cnt_d    = '0;
    end else begin
      case (mode_q)
        MODE_BLINK: begin
          if (tick) cnt_d = (cnt_q == last_cnt) ? '0 : cnt_q + TIME_W'(1);
        end
        MODE_ONESHOT: begin
          // Completion is checked every cycle so on=0 finishes without waiting a tick.
          if (cnt_q == on_q) begin
            mode_d = MODE_OFF;
            cnt_d  = '0;
            fin_d  = 1'b1;
          end else if (tick) begin
            cnt_d = cnt_q + TIME_W'(1);
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  // LED drive computed from the current state, registered below.
  always_comb begin
    led_d = 1'b0;
    case (mode_q)
      MODE_ON:                  led_d = 1'b1;
      MODE_BLINK, MODE_ONESHOT: led_d = (cnt_q < on_q);
      default:                  led_d = 1'b0;
    endcase
  end

  // Channel state; done trails the completion edge by one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q   <= MODE_W'(DEF_MODE);
      period_q <= TIME_W'(DEF_PERIOD);
      on_q     <= TIME_W'(DEF_ON);
      cnt_q    <= '0;
      led_q    <= 1'b0;
      fin_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      on_q     <= on_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      fin_q    <= fin_d;
      done_q   <= fin_q;
    end
  end

  assign led  = led_q;
  assign done = done_q;

endmodule

// File: rtl/led_blinker_multi.sv
// Multi-channel LED blinker: shared tick prescaler, valid/ready config port
// with channel decode, and one led_channel per output.
module led_blinker_multi
  import led_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned TICK_HZ     = 1000,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned TIME_W      = 16,
  parameter int unsigned DEF_MODE    = 2,
  parameter int unsigned DEF_PERIOD  = 1000,
  parameter int unsigned DEF_ON      = 500
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [3:0]          cfg_ch,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [TIME_W-1:0]   cfg_period,
  input  logic [TIME_W-1:0]   cfg_on,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] done
);

  localparam int unsigned TICK_DIV = calc_tick_div(CLK_FREQ_HZ, TICK_HZ);
  localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (TICK_DIV < 2 || TICK_HZ * TICK_DIV != CLK_FREQ_HZ) begin : g_bad_tick_div
    $error("led_blinker_multi: CLK_FREQ_HZ/TICK_HZ must be an integer >= 2");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("led_blinker_multi: CHANNELS must be 1..16");
  end

  logic [PRE_W-1:0]    pre_q;
  logic                tick;
  logic                ready_q;
  logic                err_q;
  logic                accept;
  logic                ch_ok;
  logic [CHANNELS-1:0] load;

  assign tick   = (pre_q == PRE_W'(TICK_DIV - 1));
  assign accept = cfg_valid & ready_q;
  assign ch_ok  = ({1'b0, cfg_ch} < 5'(CHANNELS));

  // Free-running prescaler; config traffic never disturbs it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pre_q <= '0;
    else       pre_q <= tick ? '0 : pre_q + PRE_W'(1);
  end

  // Handshake: ready drops for one cycle after each accept; bad channels flag an error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= ~accept;
      err_q   <= accept & ~ch_ok;
    end
  end

  // Per-channel load strobe decoded from the target channel.
  always_comb begin
    load = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      load[i] = accept & ch_ok & (cfg_ch == 4'(i));
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    led_channel #(
      .TIME_W    (TIME_W),
      .DEF_MODE  (DEF_MODE),
      .DEF_PERIOD(DEF_PERIOD),
      .DEF_ON    (DEF_ON)
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .tick      (tick),
      .load      (load[i]),
      .cfg_mode  (cfg_mode),
      .cfg_period(cfg_period),
      .cfg_on    (cfg_on),
      .led       (led[i]),
      .done      (done[i])
    );
  end

  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_led_blinker_multi.sv
// Bench for led_blinker_multi: directed scenarios plus a random phase, every
// cycle compared against a tick-counting behavioural model.
module tb_led_blinker_multi;

  localparam int CH   = 4;
  localparam int TDIV = 10;
  localparam int M_OFF = 0, M_ON = 1, M_BLINK = 2, M_ONESHOT = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [3:0]    cfg_ch = '0;
  logic [1:0]    cfg_mode = '0;
  logic [15:0]   cfg_period = '0;
  logic [15:0]   cfg_on = '0;
  logic          cfg_err;
  logic [CH-1:0] led;
  logic [CH-1:0] done;

  int total = 0, passed = 0, failed = 0;

  // Model state: edges since reset release, and per channel the ticks since load.
  int            k;
  bit            exp_ready, exp_err;
  bit [CH-1:0]   exp_led, exp_done;
  int            md[CH], pr[CH], ont[CH], nt[CH], done_at[CH];

  led_blinker_multi #(
    .CLK_FREQ_HZ(1000),
    .TICK_HZ    (100),
    .CHANNELS   (CH),
    .TIME_W     (16),
    .DEF_MODE   (2),
    .DEF_PERIOD (4),
    .DEF_ON     (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_period(cfg_period),
    .cfg_on    (cfg_on),
    .cfg_err   (cfg_err),
    .led       (led),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s at edge %0d: got %0h expected %0h", tag, k, obs, expv);
    end
  endtask

  task automatic model_reset();
    k         = 0;
    exp_ready = 1'b0;
    exp_err   = 1'b0;
    exp_led   = '0;
    exp_done  = '0;
    for (int i = 0; i < CH; i++) begin
      md[i] = M_BLINK; pr[i] = 4; ont[i] = 2; nt[i] = 0; done_at[i] = -1;
    end
  endtask

  // Expected outputs after the coming edge, then the state after it.
  task automatic model_edge();
    bit acc, tk;
    k++;
    tk        = (k % TDIV == 0);
    acc       = cfg_valid && exp_ready;
    exp_err   = acc && (int'(cfg_ch) >= CH);
    exp_ready = !acc;
    for (int i = 0; i < CH; i++) begin
      int c;
      c = (md[i] == M_BLINK) ? nt[i] % ((pr[i] == 0) ? 1 : pr[i]) : nt[i];
      exp_led[i]  = (md[i] == M_ON) ||
                    ((md[i] == M_BLINK || md[i] == M_ONESHOT) && c < ont[i]);
      exp_done[i] = (done_at[i] == k);
      if (acc && int'(cfg_ch) == i) begin
        md[i] = int'(cfg_mode); pr[i] = int'(cfg_period); ont[i] = int'(cfg_on); nt[i] = 0;
      end else if (md[i] == M_ONESHOT && nt[i] == ont[i]) begin
        md[i] = M_OFF; nt[i] = 0; done_at[i] = k + 1;
      end else if (tk && (md[i] == M_BLINK || md[i] == M_ONESHOT)) begin
        nt[i]++;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    chk("led", 32'(led), 32'(exp_led));
    chk("done", 32'(done), 32'(exp_done));
    chk("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
    chk("cfg_err", 32'(cfg_err), 32'(exp_err));
  endtask

  // Present a config and hold it until the model says it was taken.
  task automatic cfg_write(input int ch, input int mode, input int per, input int on);
    bit acc;
    cfg_valid  = 1'b1;
    cfg_ch     = 4'(ch);
    cfg_mode   = 2'(mode);
    cfg_period = 16'(per);
    cfg_on     = 16'(on);
    acc        = 1'b0;
    for (int n = 0; n < 4 && !acc; n++) begin
      acc = exp_ready;
      step();
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    // Reset values while reset is held.
    #2;
    chk("rst_led", 32'(led), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(cfg_ready), 0);
    chk("rst_err", 32'(cfg_err), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Defaults: 40-cycle, 50 % blink on every channel.
    repeat (90) step();

    // ch0 BLINK period 4, on 1.
    cfg_write(0, M_BLINK, 4, 1);
    repeat (90) step();

    // ch1 ONESHOT on 3.
    cfg_write(1, M_ONESHOT, 4, 3);
    repeat (50) step();

    // ch2 edge cases: on >= period, on = 0, period = 0.
    cfg_write(2, M_BLINK, 4, 5);
    repeat (50) step();
    cfg_write(2, M_BLINK, 4, 0);
    repeat (50) step();
    cfg_write(2, M_BLINK, 0, 1);
    repeat (50) step();

    // ONESHOT with on 0 finishes without a tick.
    cfg_write(1, M_ONESHOT, 2, 0);
    repeat (6) step();

    // Back-to-back: valid held high with stable fields.
    step();
    cfg_valid = 1'b1; cfg_ch = 4'd3; cfg_mode = 2'(M_ON); cfg_period = 16'd2; cfg_on = 16'd1;
    repeat (6) step();
    cfg_valid = 1'b0;
    step();

    // Bad channel.
    cfg_write(7, M_OFF, 1, 1);
    repeat (5) step();

    // Config landing on a tick edge.
    for (int n = 0; n < TDIV && (k % TDIV) != TDIV - 1; n++) step();
    cfg_write(0, M_BLINK, 3, 1);
    repeat (40) step();

    // Reset in the middle of a ONESHOT.
    cfg_write(3, M_ONESHOT, 2, 5);
    repeat (15) step();
    reset = 1'b1;
    #1;
    chk("async_rst_led", 32'(led), 0);
    chk("async_rst_done", 32'(done), 0);
    chk("async_rst_ready", 32'(cfg_ready), 0);
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("held_rst_led", 32'(led), 0);
    reset = 1'b0;
    repeat (80) step();

    // Random traffic, honouring the hold rule while valid is pending.
    for (int n = 0; n < 600; n++) begin
      if (!(cfg_valid && !exp_ready)) begin
        cfg_valid  = ($urandom_range(0, 15) == 0);
        cfg_ch     = 4'($urandom_range(0, 5));
        cfg_mode   = 2'($urandom_range(0, 3));
        cfg_period = 16'($urandom_range(0, 6));
        cfg_on     = 16'($urandom_range(0, 6));
      end
      step();
    end
    cfg_valid = 1'b0;
    repeat (5) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
